// File: rtl/cp_sync_ctrl_if.sv
// rtl/cp_sync_ctrl_if.sv - control/result bundle between the sync controller and the datapath.
interface cp_sync_ctrl_if #(
  parameter int MW = 32,
  parameter int TW = 9
);
  logic          start;
  logic          in_valid;
  logic          metric_valid;
  logic [MW-1:0] metric;
  logic          dl_en;
  logic          corr_clr;
  logic          busy;
  logic [1:0]    state_o;
  logic [TW-1:0] theta;
  logic [MW-1:0] peak;
  logic          theta_valid;

  modport slave (
    input  start, in_valid, metric_valid, metric,
    output dl_en, corr_clr, busy, state_o, theta, peak, theta_valid
  );

  modport master (
    output start, in_valid, metric_valid, metric,
    input  dl_en, corr_clr, busy, state_o, theta, peak, theta_valid
  );
endinterface

// File: rtl/cp_sync_ctrl.sv
// rtl/cp_sync_ctrl.sv - sequencer for CP-correlation timing sync: fill, peak search, report.
module cp_sync_ctrl #(
  parameter int N  = 256,
  parameter int L  = 16,
  parameter int MW = 32,
  parameter int TW = $clog2(N + L)
) (
  input  logic           clk,
  input  logic           rst,
  cp_sync_ctrl_if.slave  bus
);
  localparam int P  = N + L;
  localparam int CW = $clog2(P + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic [TW-1:0] idx;
  logic [TW-1:0] best_idx;
  logic [MW-1:0] best;
  logic          busy_q;
  logic          corr_clr_q;
  logic          theta_valid_q;
  logic [TW-1:0] theta_q;
  logic [MW-1:0] peak_q;

  logic take;
  logic last_metric;
  logic last_sample;

  // Index 0 always loads so an all-zero period still reports a valid peak.
  always_comb begin
    take        = (idx == '0) || (bus.metric > best);
    last_metric = (idx == TW'(P - 1));
    last_sample = (sample_cnt == CW'(P - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sample_cnt    <= '0;
      idx           <= '0;
      best_idx      <= '0;
      best          <= '0;
      busy_q        <= 1'b0;
      corr_clr_q    <= 1'b0;
      theta_valid_q <= 1'b0;
      theta_q       <= '0;
      peak_q        <= '0;
    end else begin
      corr_clr_q    <= 1'b0;
      theta_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          sample_cnt <= '0;
          if (bus.start) begin
            state      <= FILL;
            corr_clr_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FILL: begin
          if (bus.in_valid) begin
            if (last_sample) begin
              state      <= SEARCH;
              sample_cnt <= '0;
              idx        <= '0;
              best       <= '0;
              best_idx   <= '0;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (bus.metric_valid) begin
            if (take) begin
              best     <= bus.metric;
              best_idx <= idx;
            end
            // Final sample takes part in the comparison on the same edge that publishes.
            if (last_metric) begin
              theta_q       <= take ? idx : best_idx;
              peak_q        <= take ? bus.metric : best;
              theta_valid_q <= 1'b1;
              busy_q        <= 1'b0;
              state         <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          // Delay line and correlator stay primed, so re-arm skips the fill.
          if (bus.start) begin
            state    <= SEARCH;
            busy_q   <= 1'b1;
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dl_en       = bus.in_valid & (state != IDLE);
  assign bus.corr_clr    = corr_clr_q;
  assign bus.busy        = busy_q;
  assign bus.state_o     = state;
  assign bus.theta       = theta_q;
  assign bus.peak        = peak_q;
  assign bus.theta_valid = theta_valid_q;
endmodule
